// File: rtl/avst_mux_pkg.sv
// Shared types and helpers for the Avalon-ST round-robin packet multiplexer.
package avst_mux_pkg;

   // Packet-lock state: IDLE arbitrates between sop requesters, LOCKED follows one owner.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } mux_state_e;

   // Index width for n inputs, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/avst_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from last_winner+1,
// last_winner register advanced by the caller when a packet completes.
module avst_rr_arbiter
   import avst_mux_pkg::*;
#(
   parameter int  N  = 4,
   localparam int SW = sel_width(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_idx
);

   logic [SW-1:0] last_winner;
   int            rr_idx;
   logic          rr_found;

   // First requester at or after last_winner+1, wrapping modulo N
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      rr_idx    = 0;
      rr_found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         rr_idx = (int'(last_winner) + k) % N;
         if (!rr_found && req[rr_idx]) begin
            rr_found       = 1'b1;
            grant[rr_idx]  = 1'b1;
            grant_idx      = SW'(rr_idx);
         end
      end
   end

   // Reset to N-1 so input 0 holds top priority first
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     last_winner <= SW'(N - 1);
      else if (advance) last_winner <= grant_idx;
   end

endmodule

// File: rtl/avst_rr_multiplexer.sv
// Avalon-ST N:1 packet multiplexer with round-robin arbitration at packet
// boundaries and a single output register (1-cycle latency, full throughput).
// Optional macro AVST_MUX_CHANNEL_TAG_EN prepends the source index to avso_channel.
module avst_rr_multiplexer
   import avst_mux_pkg::*;
#(
   parameter int  NUM_INPUTS    = 4,
   parameter int  DATA_WIDTH    = 128,
   parameter int  EMPTY_WIDTH   = 4,
   parameter int  CHANNEL_WIDTH = 1,
   localparam int SEL_WIDTH     = sel_width(NUM_INPUTS),
`ifdef AVST_MUX_CHANNEL_TAG_EN
   localparam int CH_OUT_WIDTH  = CHANNEL_WIDTH + SEL_WIDTH
`else
   localparam int CH_OUT_WIDTH  = CHANNEL_WIDTH
`endif
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic [NUM_INPUTS-1:0][CHANNEL_WIDTH-1:0] avsi_channel,
   input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]    avsi_data,
   input  logic [NUM_INPUTS-1:0]                    avsi_valid,
   input  logic [NUM_INPUTS-1:0]                    avsi_sop,
   input  logic [NUM_INPUTS-1:0]                    avsi_eop,
   input  logic [NUM_INPUTS-1:0][EMPTY_WIDTH-1:0]   avsi_empty,
   output logic [NUM_INPUTS-1:0]                    avsi_ready,
   output logic [CH_OUT_WIDTH-1:0]                  avso_channel,
   output logic [DATA_WIDTH-1:0]                    avso_data,
   output logic [EMPTY_WIDTH-1:0]                   avso_empty,
   output logic                                     avso_valid,
   output logic                                     avso_sop,
   output logic                                     avso_eop,
   input  logic                                     avso_ready,
   output logic [SEL_WIDTH-1:0]                     grant_idx,
   output logic                                     pkt_active,
   output logic                                     orphan_drop
);

   typedef struct packed {
      logic                     sop;
      logic                     eop;
      logic [CHANNEL_WIDTH-1:0] ch;
      logic [EMPTY_WIDTH-1:0]   empty;
      logic [DATA_WIDTH-1:0]    data;
   } beat_t;

   mux_state_e            state, state_nxt;
   logic [SEL_WIDTH-1:0]  lock_idx, lock_nxt;
   logic [NUM_INPUTS-1:0] lock_oh, arb_req, arb_gnt, orphan_lane;
   logic [SEL_WIDTH-1:0]  arb_idx;
   logic                  load_en, fwd, orphan_hit;
   beat_t                 sel_beat, beat_q;
   logic                  out_vld, orphan_q;
   logic [SEL_WIDTH-1:0]  gidx_q;

   assign load_en = ~out_vld | avso_ready;

   // While locked only the owner requests, so the arbiter keeps returning it
   always_comb begin
      lock_oh           = '0;
      lock_oh[lock_idx] = 1'b1;
   end

   assign arb_req = (state == LOCKED) ? lock_oh : (avsi_valid & avsi_sop);

   avst_rr_arbiter #(.N(NUM_INPUTS)) u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (arb_req),
      .advance   (fwd & sel_beat.eop),
      .grant     (arb_gnt),
      .grant_idx (arb_idx)
   );

   // Per-lane ready: the owner follows load_en; a non-sop beat from anyone
   // else is swallowed, but only when the output is not stalled so that a
   // blocked output holds every ready low.
   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      assign orphan_lane[i] = avsi_valid[i] & ~avsi_sop[i] & ~arb_gnt[i];
      assign avsi_ready[i]  = load_en & (arb_gnt[i] | orphan_lane[i]);
   end

   assign fwd        = (|arb_gnt) & avsi_valid[arb_idx] & load_en;
   assign orphan_hit = load_en & (|orphan_lane);

   // Beat mux from the granted input
   always_comb begin
      sel_beat.sop   = avsi_sop[arb_idx];
      sel_beat.eop   = avsi_eop[arb_idx];
      sel_beat.ch    = avsi_channel[arb_idx];
      sel_beat.empty = avsi_empty[arb_idx];
      sel_beat.data  = avsi_data[arb_idx];
   end

   // Packet-lock state and owner registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         lock_idx <= '0;
      end else begin
         state    <= state_nxt;
         lock_idx <= lock_nxt;
      end
   end

   // Lock on a multi-beat sop, release on the owner's eop; a repeated sop
   // from the owner is just forwarded and the lock continues
   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_idx;
      case (state)
         IDLE: begin
            if (fwd && !sel_beat.eop) begin
               state_nxt = LOCKED;
               lock_nxt  = arb_idx;
            end
         end
         LOCKED: begin
            if (fwd && sel_beat.eop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output register: loads when empty or draining; sop/eop cleared on bubbles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld  <= 1'b0;
         beat_q   <= '0;
         gidx_q   <= '0;
         orphan_q <= 1'b0;
      end else begin
         orphan_q <= orphan_hit;
         if (load_en) begin
            out_vld <= fwd;
            if (fwd) begin
               beat_q <= sel_beat;
               gidx_q <= arb_idx;
            end else begin
               beat_q.sop <= 1'b0;
               beat_q.eop <= 1'b0;
            end
         end
      end
   end

   assign avso_valid  = out_vld;
   assign avso_sop    = beat_q.sop;
   assign avso_eop    = beat_q.eop;
   assign avso_data   = beat_q.data;
   assign avso_empty  = beat_q.empty;
   assign grant_idx   = gidx_q;
   assign pkt_active  = (state == LOCKED);
   assign orphan_drop = orphan_q;
`ifdef AVST_MUX_CHANNEL_TAG_EN
   assign avso_channel = {gidx_q, beat_q.ch};
`else
   assign avso_channel = beat_q.ch;
`endif

endmodule

// File: tb/tb_avst_rr_multiplexer.sv
// Self-checking bench for avst_rr_multiplexer (NUM_INPUTS=4, 16-bit data).
module tb_avst_rr_multiplexer;
   localparam int NI = 4, DW = 16, EW = 4, CW = 1, SW = 2;
`ifdef AVST_MUX_CHANNEL_TAG_EN
   localparam int COW = CW + SW;
`else
   localparam int COW = CW;
`endif

   logic                    clk, reset_n;
   logic [NI-1:0][CW-1:0]   avsi_channel;
   logic [NI-1:0][DW-1:0]   avsi_data;
   logic [NI-1:0]           avsi_valid, avsi_sop, avsi_eop, avsi_ready;
   logic [NI-1:0][EW-1:0]   avsi_empty;
   logic [COW-1:0]          avso_channel;
   logic [DW-1:0]           avso_data;
   logic [EW-1:0]           avso_empty;
   logic                    avso_valid, avso_sop, avso_eop, avso_ready;
   logic [SW-1:0]           grant_idx;
   logic                    pkt_active, orphan_drop;

   avst_rr_multiplexer #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_valid(avsi_valid),
      .avsi_sop(avsi_sop), .avsi_eop(avsi_eop), .avsi_empty(avsi_empty), .avsi_ready(avsi_ready),
      .avso_channel(avso_channel), .avso_data(avso_data), .avso_empty(avso_empty),
      .avso_valid(avso_valid), .avso_sop(avso_sop), .avso_eop(avso_eop), .avso_ready(avso_ready),
      .grant_idx(grant_idx), .pkt_active(pkt_active), .orphan_drop(orphan_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          sop;
      logic          eop;
      logic [DW-1:0] data;
      logic [CW-1:0] ch;
      logic [EW-1:0] empty;
   } tb_beat_t;

   int vectors = 0, fails = 0, cyc = 0;
   int ready_mode = 0;          // 0: always ready, 1: random, 2: stalled
   bit gaps = 0;

   tb_beat_t       srcq [NI][$];
   tb_beat_t       outlog[$];
   logic [COW-1:0] chlog[$];
   int             gidxlog[$];
   int             outcyc[$];

   // Reference model: packet-level rules of the mux, evaluated once per cycle
   bit            m_locked, m_ov, m_orph, m_orph_n, m_load, m_take;
   int            m_owner, m_last, m_gidx, m_win;
   tb_beat_t      m_ob, m_nb;
   bit [NI-1:0]   m_rdy;

   function automatic tb_beat_t mk(bit sop, bit eop, int data, int ch);
      tb_beat_t b;
      b.sop = sop; b.eop = eop; b.data = DW'(data); b.ch = CW'(ch); b.empty = EW'(data);
      return b;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_last = NI - 1; m_ov = 0; m_gidx = 0; m_orph = 0;
      m_ob = mk(0, 0, 0, 0);
   endtask

   task automatic model_comb();
      m_load = !m_ov || avso_ready;
      m_win  = -1;
      if (m_locked) m_win = m_owner;
      else
         for (int k = 1; k <= NI; k++) begin
            int j;
            j = (m_last + k) % NI;
            if (m_win < 0 && avsi_valid[j] && avsi_sop[j]) m_win = j;
         end
      m_orph_n = 0;
      for (int i = 0; i < NI; i++) begin
         bit orph;
         orph     = avsi_valid[i] && !avsi_sop[i] && (i != m_win);
         m_rdy[i] = m_load && ((i == m_win) || orph);
         if (m_load && orph) m_orph_n = 1;
      end
      m_take = (m_win >= 0) && m_load && avsi_valid[m_win];
      if (m_take)
         m_nb = mk(avsi_sop[m_win], avsi_eop[m_win], int'(avsi_data[m_win]), int'(avsi_channel[m_win]));
   endtask

   task automatic model_seq();
      if (m_load) begin
         m_ov = m_take;
         if (m_take) begin m_ob = m_nb; m_gidx = m_win; end
      end
      if (m_take) begin
         if (!m_locked && !m_nb.eop) begin m_locked = 1; m_owner = m_win; end
         else if (m_locked && m_nb.eop) m_locked = 0;
         if (m_nb.eop) m_last = m_win;
      end
      m_orph = m_orph_n;
   endtask

   // Present queue heads (with optional gaps) and the sink ready
   task automatic drive();
      for (int i = 0; i < NI; i++) begin
         if (srcq[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            avsi_valid[i]   = 1'b1;
            avsi_sop[i]     = srcq[i][0].sop;
            avsi_eop[i]     = srcq[i][0].eop;
            avsi_data[i]    = srcq[i][0].data;
            avsi_channel[i] = srcq[i][0].ch;
            avsi_empty[i]   = srcq[i][0].empty;
         end else begin
            avsi_valid[i]   = 1'b0;
            avsi_sop[i]     = 1'($urandom);
            avsi_eop[i]     = 1'($urandom);
            avsi_data[i]    = DW'($urandom);
            avsi_channel[i] = CW'($urandom);
            avsi_empty[i]   = EW'($urandom);
         end
      end
      avso_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(3) != 0);
   endtask

   // One clock: check ready, log output transfers, advance model, check outputs
   task automatic tick();
      logic [COW-1:0] ech;
      tb_beat_t       ob;
      #1;
      model_comb();
      vectors++;
      if (avsi_ready !== m_rdy) begin
         fails++; $display("FAIL avsi_ready cyc=%0d got=%b exp=%b", cyc, avsi_ready, m_rdy);
      end
      if (avso_valid && avso_ready) begin
         ob = mk(avso_sop, avso_eop, int'(avso_data), 0);
         outlog.push_back(ob); chlog.push_back(avso_channel);
         gidxlog.push_back(int'(grant_idx)); outcyc.push_back(cyc);
      end
      for (int i = 0; i < NI; i++)
         if (avsi_valid[i] && m_rdy[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      @(posedge clk);
      model_seq();
      cyc++;
      @(negedge clk);
`ifdef AVST_MUX_CHANNEL_TAG_EN
      ech = {SW'(m_gidx), m_ob.ch};
`else
      ech = m_ob.ch;
`endif
      vectors++;
      if (avso_valid !== m_ov) begin
         fails++; $display("FAIL avso_valid cyc=%0d got=%b exp=%b", cyc, avso_valid, m_ov);
      end
      if (m_ov) begin
         vectors++;
         if ({avso_sop, avso_eop, avso_data, avso_empty, avso_channel} !==
             {m_ob.sop, m_ob.eop, m_ob.data, m_ob.empty, ech}) begin
            fails++;
            $display("FAIL out_beat cyc=%0d got sop=%b eop=%b d=%h e=%h ch=%h exp sop=%b eop=%b d=%h e=%h ch=%h",
                     cyc, avso_sop, avso_eop, avso_data, avso_empty, avso_channel,
                     m_ob.sop, m_ob.eop, m_ob.data, m_ob.empty, ech);
         end
      end
      vectors++;
      if (int'(grant_idx) != m_gidx) begin
         fails++; $display("FAIL grant_idx cyc=%0d got=%0d exp=%0d", cyc, grant_idx, m_gidx);
      end
      vectors++;
      if (pkt_active !== m_locked) begin
         fails++; $display("FAIL pkt_active cyc=%0d got=%b exp=%b", cyc, pkt_active, m_locked);
      end
      vectors++;
      if (orphan_drop !== m_orph) begin
         fails++; $display("FAIL orphan_drop cyc=%0d got=%b exp=%b", cyc, orphan_drop, m_orph);
      end
   endtask

   task automatic run(int n);
      repeat (n) begin drive(); tick(); end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NI; i++) if (srcq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_logs();
      outlog.delete(); chlog.delete(); gidxlog.delete(); outcyc.delete();
   endtask

   task automatic idle_inputs();
      avsi_valid = '0; avsi_sop = '0; avsi_eop = '0;
      avsi_data = '0; avsi_channel = '0; avsi_empty = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      for (int i = 0; i < NI; i++) srcq[i].delete();
      @(negedge clk);
      reset_n = 1'b1;
      model_reset(); clear_logs();
      ready_mode = 0; gaps = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; idle_inputs(); avso_ready = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      vectors++;
      if ({avso_valid, avso_sop, avso_eop, avso_data, avso_channel, avso_empty, grant_idx, pkt_active, orphan_drop} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got v=%b s=%b e=%b d=%h ch=%h em=%h g=%0d pa=%b od=%b exp all 0",
                  avso_valid, avso_sop, avso_eop, avso_data, avso_channel, avso_empty, grant_idx, pkt_active, orphan_drop);
      end
      // Requests during reset must not reach the output
      avsi_valid = 4'b0011; avsi_sop = 4'b0001;
      repeat (2) @(negedge clk);
      vectors++;
      if (avso_valid !== 1'b0 || orphan_drop !== 1'b0) begin
         fails++; $display("FAIL reset_hold got v=%b od=%b exp 0 0", avso_valid, orphan_drop);
      end
      idle_inputs();
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_two_packets();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         srcq[0].push_back(mk(k == 0, k == 2, 16'h0a00 + k, 0));
         srcq[2].push_back(mk(k == 0, k == 2, 16'h0c00 + k, 0));
      end
      run(10);
      vectors++;
      if (outlog.size() != 6) begin
         fails++; $display("FAIL two_pkt_count got=%0d exp=6", outlog.size());
      end else begin
         vectors++;
         if (outcyc[5] - outcyc[0] != 5) begin
            fails++; $display("FAIL two_pkt_contiguous got span=%0d exp=5", outcyc[5] - outcyc[0]);
         end
         for (int k = 0; k < 6; k++) begin
            int ed, eg;
            ed = (k < 3) ? 16'h0a00 + k : 16'h0c00 + k - 3;
            eg = (k < 3) ? 0 : 2;
            vectors++;
            if (int'(outlog[k].data) != ed || gidxlog[k] != eg) begin
               fails++; $display("FAIL two_pkt_beat%0d got d=%h g=%0d exp d=%h g=%0d", k, outlog[k].data, gidxlog[k], ed, eg);
            end
         end
      end
   endtask

   task automatic test_single_beat_rr();
      do_reset();
      for (int i = 0; i < NI; i++)
         for (int k = 0; k < 8; k++) srcq[i].push_back(mk(1, 1, (i << 8) | k, i));
      run(12);
      vectors++;
      if (outlog.size() < 8) begin
         fails++; $display("FAIL rr_count got=%0d exp>=8", outlog.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            vectors++;
            if (gidxlog[k] != k % NI || outcyc[k] != outcyc[0] + k) begin
               fails++; $display("FAIL rr_seq%0d got g=%0d cyc=%0d exp g=%0d cyc=%0d", k, gidxlog[k], outcyc[k], k % NI, outcyc[0] + k);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DW+2:0] frozen;
      do_reset();
      for (int k = 0; k < 4; k++) srcq[1].push_back(mk(k == 0, k == 3, 16'h1100 + k, 1));
      run(2);
      frozen = {avso_valid, avso_sop, avso_eop, avso_data};
      ready_mode = 2;
      repeat (5) begin
         drive();
         #1;
         vectors++;
         if (avsi_ready !== '0) begin
            fails++; $display("FAIL stall_ready got=%b exp=0000", avsi_ready);
         end
         tick();
         vectors++;
         if ({avso_valid, avso_sop, avso_eop, avso_data} !== frozen) begin
            fails++; $display("FAIL stall_frozen got=%h exp=%h", {avso_valid, avso_sop, avso_eop, avso_data}, frozen);
         end
      end
      ready_mode = 0;
      run(6);
      vectors++;
      if (outlog.size() != 4) begin
         fails++; $display("FAIL stall_count got=%0d exp=4", outlog.size());
      end else
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (int'(outlog[k].data) != 16'h1100 + k) begin
               fails++; $display("FAIL stall_beat%0d got=%h exp=%h", k, outlog[k].data, 16'h1100 + k);
            end
         end
   endtask

   task automatic test_orphan();
      do_reset();
      srcq[3].push_back(mk(0, 0, 16'h3333, 0));
      drive();
      #1;
      vectors++;
      if (avsi_ready[3] !== 1'b1) begin
         fails++; $display("FAIL orphan_ready got=%b exp=1", avsi_ready[3]);
      end
      tick();
      vectors++;
      if (orphan_drop !== 1'b1 || avso_valid !== 1'b0) begin
         fails++; $display("FAIL orphan_pulse got od=%b v=%b exp 1 0", orphan_drop, avso_valid);
      end
      run(1);
      vectors++;
      if (orphan_drop !== 1'b0 || avso_valid !== 1'b0) begin
         fails++; $display("FAIL orphan_after got od=%b v=%b exp 0 0", orphan_drop, avso_valid);
      end
   endtask

   task automatic test_reset_midpkt();
      do_reset();
      for (int k = 0; k < 4; k++) srcq[0].push_back(mk(k == 0, k == 3, 16'h0b00 + k, 0));
      run(2);
      drive();
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (avso_valid !== 1'b0 || pkt_active !== 1'b0 || grant_idx !== '0) begin
         fails++; $display("FAIL midpkt_reset got v=%b pa=%b g=%0d exp 0 0 0", avso_valid, pkt_active, grant_idx);
      end
      idle_inputs();
      for (int i = 0; i < NI; i++) srcq[i].delete();
      @(negedge clk);
      reset_n = 1'b1;
      model_reset(); clear_logs();
      srcq[0].push_back(mk(1, 1, 16'h0e0e, 0));
      run(3);
      vectors++;
      if (outlog.size() != 1 || (outlog.size() == 1 && (int'(outlog[0].data) != 16'h0e0e || gidxlog[0] != 0))) begin
         fails++; $display("FAIL midpkt_restart got n=%0d exp one beat 0e0e from input 0", outlog.size());
      end
   endtask

   task automatic test_channel_tag();
      logic [COW-1:0] ech;
`ifdef AVST_MUX_CHANNEL_TAG_EN
      ech = 3'b101;
`else
      ech = 1'b1;
`endif
      do_reset();
      srcq[2].push_back(mk(1, 1, 16'h2222, 1));
      run(3);
      vectors++;
      if (chlog.size() != 1) begin
         fails++; $display("FAIL chan_count got=%0d exp=1", chlog.size());
      end else begin
         vectors++;
         if (chlog[0] !== ech) begin
            fails++; $display("FAIL chan_tag got=%b exp=%b", chlog[0], ech);
         end
      end
   endtask

   task automatic test_random();
      int exp_beats = 0, seq = 0, budget = 0;
      do_reset();
      for (int i = 0; i < NI; i++)
         for (int p = 0; p < 6; p++) begin
            if ($urandom_range(5) == 0) begin
               srcq[i].push_back(mk(0, 1'($urandom), (i << 12) | seq, i)); seq++;
            end else begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  srcq[i].push_back(mk((b == 0) || ($urandom_range(9) == 0), b == len - 1, (i << 12) | seq, $urandom));
                  seq++;
               end
               exp_beats += len;
            end
         end
      ready_mode = 1; gaps = 1;
      while (pending() && budget < 2000) begin run(1); budget++; end
      vectors++;
      if (pending()) begin
         fails++; $display("FAIL random_timeout got pending after %0d cycles exp drained", budget);
      end
      ready_mode = 0; gaps = 0;
      run(3);
      vectors++;
      if (outlog.size() != exp_beats) begin
         fails++; $display("FAIL random_beats got=%0d exp=%0d", outlog.size(), exp_beats);
      end
   endtask

   initial begin
      test_reset();
      test_two_packets();
      test_single_beat_rr();
      test_backpressure();
      test_orphan();
      test_reset_midpkt();
      test_channel_tag();
      repeat (3) test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
